// File: rtl/design_32_issuer.sv
// design_32_issuer
//   Initiator for the design_32 compute engine. Takes one operand pair from
//   upstream, pulses eng_start, and waits for eng_valid. It then holds the
//   captured result for downstream until out_ready accepts it. Only one
//   transaction is in flight at a time.
//
//   Optional feature: define DESIGN_32_ISSUER_TIMEOUT_EN to enable the WAIT
//   timer. When it expires, the transaction is aborted with out_err=1 and
//   out_y=0. Without the macro, WAIT lasts until eng_valid arrives and
//   out_err is tied to 0.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid/in_ready     upstream operand handshake, operands in_a/in_b
//   eng_start             one-cycle start pulse to the engine
//   eng_a/eng_b           operands held stable toward the engine
//   eng_y/eng_valid       engine result
//   out_valid/out_ready   downstream result handshake, out_y/out_err
//   done_cnt              completed transfers (ok + timeout), wraps
//   spur_cnt              eng_valid seen outside WAIT, saturates at 255
module design_32_issuer #(
  parameter int W       = 12,
  parameter int TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         eng_start,
  output logic [W-1:0] eng_a,
  output logic [W-1:0] eng_b,
  input  logic [W-1:0] eng_y,
  input  logic         eng_valid,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_y,
  output logic         out_err,
  output logic [15:0]  done_cnt,
  output logic [7:0]   spur_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;

  state_t       state_q;
  logic         in_ready_q;
  logic         eng_start_q;
  logic [W-1:0] eng_a_q, eng_b_q;
  logic         out_valid_q;
  logic [W-1:0] out_y_q;
  logic [15:0]  done_cnt_q, done_cnt_d;
  logic [7:0]   spur_cnt_q, spur_cnt_d;

`ifdef DESIGN_32_ISSUER_TIMEOUT_EN
  // Timer counts WAIT cycles from 0; the last legal WAIT cycle is TIMEOUT-1.
  localparam logic [7:0] TMAX = 8'(TIMEOUT - 1);
  logic [7:0] timer_q;
  logic       out_err_q;
  assign out_err = out_err_q;
`else
  assign out_err = 1'b0;
`endif

  // A valid outside WAIT is spurious; the counter sticks at 255.
  always_comb begin
    spur_cnt_d = spur_cnt_q;
    if (eng_valid && (state_q != S_WAIT) && (spur_cnt_q != 8'hFF))
      spur_cnt_d = spur_cnt_q + 8'd1;
  end

  assign done_cnt_d = done_cnt_q + 16'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b0;
      eng_start_q <= 1'b0;
      eng_a_q     <= '0;
      eng_b_q     <= '0;
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
      done_cnt_q  <= '0;
      spur_cnt_q  <= '0;
`ifdef DESIGN_32_ISSUER_TIMEOUT_EN
      timer_q     <= '0;
      out_err_q   <= 1'b0;
`endif
    end else begin
      eng_start_q <= 1'b0;
      spur_cnt_q  <= spur_cnt_d;
      case (state_q)
        S_IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            eng_a_q     <= in_a;
            eng_b_q     <= in_b;
            in_ready_q  <= 1'b0;
            eng_start_q <= 1'b1;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
`ifdef DESIGN_32_ISSUER_TIMEOUT_EN
          timer_q <= '0;
`endif
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // eng_valid is checked first so it wins on the timeout cycle.
          if (eng_valid) begin
            out_y_q     <= eng_y;
            out_valid_q <= 1'b1;
`ifdef DESIGN_32_ISSUER_TIMEOUT_EN
            out_err_q   <= 1'b0;
`endif
            state_q     <= S_HOLD;
          end
`ifdef DESIGN_32_ISSUER_TIMEOUT_EN
          else if (timer_q == TMAX) begin
            out_y_q     <= '0;
            out_err_q   <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= S_HOLD;
          end else begin
            timer_q <= timer_q + 8'd1;
          end
`endif
        end
        S_HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            done_cnt_q  <= done_cnt_d;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign eng_start = eng_start_q;
  assign eng_a     = eng_a_q;
  assign eng_b     = eng_b_q;
  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;
  assign done_cnt  = done_cnt_q;
  assign spur_cnt  = spur_cnt_q;

endmodule
